// File: rtl/lenet_batch_ctrl_pkg.sv
// Shared definitions for the LeNet batch controller: FSM encoding, digit width
// and the marker digit written when the core fails to respond in time.
package lenet_batch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_STORE,
    ST_NEXT,
    ST_FIN
  } state_t;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] TIMEOUT_DIGIT = 4'hF;

endpackage

// File: rtl/lenet_batch_ctrl_rise.sv
// Registered rising-edge detector on the LeNet core ready line; works for
// both pulsed and level-style ready signalling.
module lenet_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic ready,
  output logic rise
);

  logic ready_q;

  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= ready;
  end

  assign rise = ready & ~ready_q;

endmodule

// File: rtl/lenet_batch_ctrl.sv
// Batch controller: launches the LeNet core once per image, waits for its
// ready edge (or a timeout) and writes each digit into the result buffer.
module lenet_batch_ctrl
  import lenet_batch_ctrl_pkg::*;
#(
  parameter int unsigned NIMG_W  = 8,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NIMG_W-1:0]  num_images,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               lenet_go,
  output logic [NIMG_W-1:0]  img_sel,
  input  logic               lenet_ready,
  input  logic [DIGIT_W-1:0] lenet_digit,
  output logic               res_we,
  output logic [NIMG_W-1:0]  res_addr,
  output logic [DIGIT_W-1:0] res_data
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state;
  logic [NIMG_W-1:0]   idx;
  logic [NIMG_W-1:0]   count;
  logic [CNT_W-1:0]    wait_cnt;
  logic                ready_rise;

  lenet_rise_det u_rise_det (
    .clk   (clk),
    .rst   (rst),
    .ready (lenet_ready),
    .rise  (ready_rise)
  );

  assign img_sel = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      count       <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      lenet_go    <= 1'b0;
      res_we      <= 1'b0;
      res_addr    <= '0;
      res_data    <= '0;
    end else begin
      lenet_go <= 1'b0;
      res_we   <= 1'b0;
      done     <= 1'b0;
      // abort outranks every state transition, including the FIN completion pulse
      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              busy        <= 1'b1;
              err_timeout <= 1'b0;
              count       <= num_images;
              idx         <= '0;
              if (num_images != '0) begin
                lenet_go <= 1'b1;
                state    <= ST_LAUNCH;
              end else begin
                state <= ST_FIN;
              end
            end
          end
          ST_LAUNCH: begin
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end
          ST_WAIT: begin
            if (ready_rise) begin
              res_data <= lenet_digit;
              res_addr <= idx;
              res_we   <= 1'b1;
              state    <= ST_STORE;
            end else if (wait_cnt == CNT_LAST) begin
              res_data    <= TIMEOUT_DIGIT;
              res_addr    <= idx;
              res_we      <= 1'b1;
              err_timeout <= 1'b1;
              state       <= ST_STORE;
            end else if (wait_cnt != '1) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          ST_STORE: state <= ST_NEXT;
          ST_NEXT: begin
            if (idx == count - 1'b1) begin
              state <= ST_FIN;
            end else begin
              idx      <= idx + 1'b1;
              lenet_go <= 1'b1;
              state    <= ST_LAUNCH;
            end
          end
          ST_FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lenet_batch_ctrl.sv
// Self-checking bench for lenet_batch_ctrl: behavioural LeNet core model,
// output monitor and per-batch scoreboard derived from the batch rules.
module tb_lenet_batch_ctrl;

  localparam int unsigned NW = 3;
  localparam int unsigned TO = 120;
  localparam int M_PULSE = 0;
  localparam int M_LEVEL = 1;
  localparam int M_NEVER = 2;
  localparam int M_PRE   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] num_images;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err_timeout;
  logic          lenet_go;
  logic [NW-1:0] img_sel;
  logic          lenet_ready;
  logic [3:0]    lenet_digit;
  logic          res_we;
  logic [NW-1:0] res_addr;
  logic [3:0]    res_data;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         core_mode;
  logic       hold_pre;
  int         dly [8];
  logic [3:0] dig [8];

  int          cyc_now = 0;
  int          go_cnt = 0;
  int          done_cnt = 0;
  logic [NW-1:0] wr_addr [$];
  logic [3:0]    wr_data [$];
  int            wr_cyc  [$];
  int            rise_cyc [$];
  int            cd;
  int            drop_cd;

  lenet_batch_ctrl #(.NIMG_W(NW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_images  (num_images),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .lenet_go    (lenet_go),
    .img_sel     (img_sel),
    .lenet_ready (lenet_ready),
    .lenet_digit (lenet_digit),
    .res_we      (res_we),
    .res_addr    (res_addr),
    .res_data    (res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  // LeNet core model: answers dly[img] cycles after each go, in the configured style
  always @(negedge clk) begin
    if (rst) begin
      lenet_ready = 1'b0;
      lenet_digit = 4'h0;
      cd = 0;
      drop_cd = 0;
    end else begin
      if (core_mode == M_PULSE && lenet_ready) lenet_ready = 1'b0;
      if (core_mode == M_PRE && hold_pre) begin
        lenet_ready = 1'b1;
        lenet_digit = 4'h3;
      end
      if (lenet_go) begin
        case (core_mode)
          M_PULSE, M_LEVEL: begin lenet_ready = 1'b0; cd = dly[img_sel]; drop_cd = 0; end
          M_NEVER:          begin lenet_ready = 1'b0; cd = 0; drop_cd = 0; end
          default:          begin drop_cd = 2; cd = 12; end
        endcase
      end else begin
        if (drop_cd > 0) begin
          drop_cd--;
          if (drop_cd == 0) lenet_ready = 1'b0;
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            lenet_ready = 1'b1;
            lenet_digit = dig[img_sel];
            rise_cyc.push_back(cyc_now);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (lenet_go) go_cnt++;
      if (done) done_cnt++;
      if (res_we) begin
        wr_addr.push_back(res_addr);
        wr_data.push_back(res_data);
        wr_cyc.push_back(cyc_now);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_batch(input int n, input int mode_i);
    int w0, g0, d0, cyc, budget;
    logic exp_err, timed_out;
    logic [3:0] ed;
    w0 = wr_addr.size(); g0 = go_cnt; d0 = done_cnt;
    core_mode = mode_i;
    @(posedge clk); #1;
    start = 1'b1; num_images = NW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    hold_pre = 1'b0;
    check("go_latency", lenet_go, n != 0);
    check("busy_after_start", busy, 1);
    cyc = 0; budget = n * (int'(TO) + 6) + 10;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("done_in_budget", cyc < budget, 1);
    if (n == 0) check("zero_done_latency", cyc, 1);
    @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("go_count", go_cnt - g0, n);
    check("write_count", wr_addr.size() - w0, n);
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      // the d-th WAIT cycle beats the timeout only while d <= TIMEOUT
      timed_out = (mode_i == M_NEVER) ||
                  ((mode_i == M_PULSE || mode_i == M_LEVEL) && dly[i] > int'(TO));
      ed = timed_out ? 4'hF : dig[i];
      exp_err |= timed_out;
      if (w0 + i < wr_addr.size()) begin
        check("wr_addr", wr_addr[w0+i], i);
        check("wr_data", wr_data[w0+i], ed);
      end
    end
    check("err_timeout", err_timeout, exp_err);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int w0, g0, d0, r0, cyc, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_images = '0;
    core_mode = M_PULSE; hold_pre = 1'b0;
    for (int i = 0; i < 8; i++) begin dly[i] = 1; dig[i] = 4'h0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_go", lenet_go, 0);
    check("rst_we", res_we, 0);
    check("rst_err", err_timeout, 0);
    check("rst_img_sel", img_sel, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // three images, 100-cycle core, digits 7,2,1 plus ready->we latency
    dly[0] = 100; dly[1] = 100; dly[2] = 100;
    dig[0] = 4'd7; dig[1] = 4'd2; dig[2] = 4'd1;
    w0 = wr_addr.size(); r0 = rise_cyc.size();
    run_batch(3, M_PULSE);
    for (int i = 0; i < 3; i++)
      if (r0 + i < rise_cyc.size() && w0 + i < wr_cyc.size())
        check("ready_to_we_latency", wr_cyc[w0+i] - rise_cyc[r0+i], 1);

    // out-of-range digits pass through, level-style ready
    dly[0] = 5; dly[1] = 9; dly[2] = 2;
    dig[0] = 4'd10; dig[1] = 4'd15; dig[2] = 4'd12;
    run_batch(3, M_LEVEL);

    run_batch(2, M_NEVER);
    run_batch(0, M_PULSE);

    // timeout boundary: last WAIT cycle still captures, one later does not
    dly[0] = int'(TO); dig[0] = 4'd4;
    run_batch(1, M_PULSE);
    dly[0] = int'(TO) + 1;
    run_batch(1, M_PULSE);

    // full count without wrap
    for (int i = 0; i < 8; i++) begin dly[i] = 3; dig[i] = 4'(i + 1); end
    run_batch(7, M_PULSE);

    // ready held high through LAUNCH: only the second rise is captured
    dig[0] = 4'd9;
    core_mode = M_PRE; hold_pre = 1'b1;
    repeat (4) @(negedge clk);
    run_batch(1, M_PRE);

    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < 8; i++) begin
        dly[i] = ($urandom % 8 == 0) ? int'(TO) - 1 + int'($urandom % 3) : int'($urandom_range(1, 60));
        dig[i] = 4'($urandom);
      end
      run_batch(n, int'($urandom_range(0, 1)));
    end

    // abort during WAIT of image 1 of 4; image 0 timed out so err must persist
    dly[0] = int'(TO) + 1; dly[1] = 60; dly[2] = 5; dly[3] = 5;
    core_mode = M_PULSE;
    w0 = wr_addr.size(); g0 = go_cnt; d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1; num_images = NW'(4);
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (go_cnt - g0 < 2 && cyc < 400) begin @(negedge clk); cyc++; end
    check("abort_reach_img1", cyc < 400, 1);
    repeat (20) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_go", lenet_go, 0);
    repeat (200) @(negedge clk);
    check("abort_writes", wr_addr.size() - w0, 1);
    if (wr_addr.size() > w0) begin
      check("abort_addr", wr_addr[w0], 0);
      check("abort_data", wr_data[w0], 4'hF);
    end
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_go_count", go_cnt - g0, 2);
    check("abort_err_kept", err_timeout, 1);

    // abort coincident with start in IDLE
    g0 = go_cnt;
    @(posedge clk); #1; start = 1'b1; abort = 1'b1; num_images = NW'(2);
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("abort_start_go", go_cnt - g0, 0);

    // start re-pulsed while busy is ignored
    dly[0] = 30; dly[1] = 30; dig[0] = 4'd5; dig[1] = 4'd6;
    w0 = wr_addr.size(); g0 = go_cnt; d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1; num_images = NW'(2);
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; start = 1'b1; num_images = NW'(5);
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
    check("restart_done_in_budget", cyc < 400, 1);
    repeat (5) @(negedge clk);
    check("restart_writes", wr_addr.size() - w0, 2);
    check("restart_go_count", go_cnt - g0, 2);
    check("restart_done_once", done_cnt - d0, 1);

    // reset mid-batch
    dly[0] = 40; dly[1] = 40; dly[2] = 40;
    g0 = go_cnt; d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1; num_images = NW'(3);
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (go_cnt - g0 < 2 && cyc < 400) begin @(negedge clk); cyc++; end
    check("rst_reach_img1", cyc < 400, 1);
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_go", lenet_go, 0);
    check("midrst_we", res_we, 0);
    check("midrst_err", err_timeout, 0);
    check("midrst_img_sel", img_sel, 0);
    check("midrst_res_addr", res_addr, 0);
    check("midrst_res_data", res_data, 0);
    @(posedge clk); #1; rst = 1'b0;
    g0 = go_cnt;
    repeat (200) @(negedge clk);
    check("midrst_no_relaunch", go_cnt - g0, 0);
    check("midrst_no_done", done_cnt - d0, 0);
    dly[0] = 7; dig[0] = 4'd8;
    run_batch(1, M_PULSE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
